stopwatch_up: RTL and testbench

Count-up stopwatch for the two-digit seven-segment timer board. It is the counting counterpart of the existing countdown timer. It runs from the board clock with an internal one-second tick enable, which keeps the design in a single clock domain. It counts 00–99 seconds in BCD, supports start/stop, lap freeze and clear, and can stop at a programmable target. It drives the same active-low segment outputs as the countdown timer.

---
 rtl/stopwatch_up_pkg.sv | 26 ++
 rtl/stopwatch_up_bcd_to_seg7.sv | 26 ++
 rtl/stopwatch_up.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_up.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_up_pkg.sv
// rtl/stopwatch_up_pkg.sv - shared types and segment constants for the count-up stopwatch
package stopwatch_up_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    // Active-low {a..g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001101;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/stopwatch_up_bcd_to_seg7.sv
// rtl/stopwatch_up_bcd_to_seg7.sv - combinational BCD digit to active-low seven-segment decoder
module bcd_to_seg7
    import stopwatch_up_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_up.sv
// rtl/stopwatch_up.sv - 00-99 s BCD count-up stopwatch with start/stop, lap freeze, clear and stop target
module stopwatch_up
    import stopwatch_up_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_n,
    input  logic       lap_n,
    input  logic [3:0] target_tens,
    input  logic [3:0] target_ones,
    output logic [6:0] seg_ones,
    output logic [6:0] seg_tens,
    output logic       running,
    output logic       lap_active,
    output logic       done
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    logic start_s1_q, start_s2_q, start_prev_q, start_press_q;
    logic lap_s1_q, lap_s2_q, lap_prev_q, lap_press_q;

    state_e           state_q, state_d;
    bcd_t             ones_q, ones_d, tens_q, tens_d;
    bcd_t             lap_ones_q, lap_ones_d, lap_tens_q, lap_tens_d;
    logic             lap_q, lap_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             running_q, done_q;

    bcd_t inc_ones, inc_tens;
    logic tick, target_valid, hit;

    // Press events are registered so each press yields exactly one clean cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            start_s1_q    <= 1'b1;
            start_s2_q    <= 1'b1;
            start_prev_q  <= 1'b1;
            start_press_q <= 1'b0;
            lap_s1_q      <= 1'b1;
            lap_s2_q      <= 1'b1;
            lap_prev_q    <= 1'b1;
            lap_press_q   <= 1'b0;
        end else begin
            start_s1_q    <= start_n;
            start_s2_q    <= start_s1_q;
            start_prev_q  <= start_s2_q;
            start_press_q <= start_prev_q & ~start_s2_q;
            lap_s1_q      <= lap_n;
            lap_s2_q      <= lap_s1_q;
            lap_prev_q    <= lap_s2_q;
            lap_press_q   <= lap_prev_q & ~lap_s2_q;
        end
    end

    assign tick = (state_q == ST_RUN) && (pre_q == PRE_MAX);

    always_comb begin
        inc_ones = ones_q + 4'd1;
        inc_tens = tens_q;
        if (ones_q == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
        end
    end

    assign target_valid = (target_tens <= 4'd9) && (target_ones <= 4'd9) &&
                          !((target_tens == 4'd0) && (target_ones == 4'd0));
    assign hit = tick && target_valid && (inc_tens == target_tens) && (inc_ones == target_ones);

    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        lap_ones_d = lap_ones_q;
        lap_tens_d = lap_tens_q;
        lap_d      = lap_q;
        pre_d      = pre_q;
        case (state_q)
            ST_IDLE: begin
                if (start_press_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                pre_d = tick ? '0 : pre_q + PRE_W'(1);
                if (tick) begin
                    ones_d = inc_ones;
                    tens_d = inc_tens;
                end
                // Reaching the target outranks a simultaneous stop press.
                if (hit) state_d = ST_DONE;
                else if (start_press_q) state_d = ST_HOLD;
                if (lap_press_q) begin
                    lap_d = ~lap_q;
                    if (!lap_q) begin
                        lap_ones_d = ones_q;
                        lap_tens_d = tens_q;
                    end
                end
            end
            ST_HOLD: begin
                if (start_press_q) begin
                    state_d = ST_RUN;
                end else if (lap_press_q) begin
                    state_d = ST_IDLE;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    lap_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (start_press_q) begin
                    state_d = ST_IDLE;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    lap_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) pre_d = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            lap_ones_q <= 4'd0;
            lap_tens_q <= 4'd0;
            lap_q      <= 1'b0;
            pre_q      <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            lap_ones_q <= lap_ones_d;
            lap_tens_q <= lap_tens_d;
            lap_q      <= lap_d;
            pre_q      <= pre_d;
            running_q  <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign running    = running_q;
    assign done       = done_q;
    assign lap_active = lap_q;

    bcd_to_seg7 u_seg_ones (
        .bcd_i (lap_q ? lap_ones_q : ones_q),
        .seg_o (seg_ones)
    );

    bcd_to_seg7 u_seg_tens (
        .bcd_i (lap_q ? lap_tens_q : tens_q),
        .seg_o (seg_tens)
    );

endmodule

// File: tb/tb_stopwatch_up.sv
// tb/tb_stopwatch_up.sv - randomized scoreboard bench for stopwatch_up against a seconds-level model
module tb_stopwatch_up;

    localparam int T = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

    logic       clock = 1'b0;
    logic       reset, start_n, lap_n;
    logic [3:0] target_tens, target_ones;
    logic [6:0] seg_ones, seg_tens;
    logic       running, lap_active, done;

    always #5 clock = ~clock;

    stopwatch_up #(.TICKS_PER_SEC(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .start_n     (start_n),
        .lap_n       (lap_n),
        .target_tens (target_tens),
        .target_ones (target_ones),
        .seg_ones    (seg_ones),
        .seg_tens    (seg_tens),
        .running     (running),
        .lap_active  (lap_active),
        .done        (done)
    );

    logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                  7'b0100100, 7'b0100000, 7'b0001101, 7'b0000000, 7'b0000100};

    int  m_state, m_count, m_lap_val, m_pre;
    bit  m_lap;
    bit  hs[$], hl[$];
    logic [16:0] exp_q[$];
    int  n_checks = 0, n_fail = 0;
    int  n_done = 0, n_wraps = 0;

    task automatic model_step();
        bit sp, lp, tvalid, tick, dropped;
        int tv, nc, disp;
        if (!reset) begin
            m_state = M_IDLE; m_count = 0; m_lap_val = 0; m_pre = 0; m_lap = 0;
            hs = '{1, 1, 1, 1};
            hl = '{1, 1, 1, 1};
        end else begin
            // hs[k] holds the button as seen k+1 edges ago
            sp = (hs[2] == 0) && (hs[3] == 1);
            lp = (hl[2] == 0) && (hl[3] == 1);
            hs.push_front(start_n); dropped = hs.pop_back();
            hl.push_front(lap_n);   dropped = hl.pop_back();
            tv     = int'(target_tens) * 10 + int'(target_ones);
            tvalid = (target_tens <= 9) && (target_ones <= 9) && (tv != 0);
            tick   = (m_state == M_RUN) && (m_pre == T - 1);
            nc     = tick ? (m_count + 1) % 100 : m_count;
            case (m_state)
                M_IDLE: if (sp) m_state = M_RUN;
                M_RUN: begin
                    m_pre = tick ? 0 : m_pre + 1;
                    if (lp) begin
                        if (!m_lap) m_lap_val = m_count;
                        m_lap = !m_lap;
                    end
                    if (tick && m_count == 99) n_wraps++;
                    m_count = nc;
                    if (tick && tvalid && nc == tv) begin
                        m_state = M_DONE;
                        n_done++;
                    end else if (sp) m_state = M_HOLD;
                end
                M_HOLD: begin
                    if (sp) m_state = M_RUN;
                    else if (lp) begin m_state = M_IDLE; m_count = 0; m_lap = 0; end
                end
                default: if (sp) begin m_state = M_IDLE; m_count = 0; m_lap = 0; end
            endcase
            if (m_state == M_IDLE) m_pre = 0;
        end
        disp = m_lap ? m_lap_val : m_count;
        exp_q.push_back({seg_tab[disp / 10], seg_tab[disp % 10],
                         m_state == M_RUN, m_lap, m_state == M_DONE});
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        logic [16:0] act, expv;
        @(posedge clock);
        #1;
        act = {seg_tens, seg_ones, running, lap_active, done};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: actual %b, no expected entry", $time, act);
        end else begin
            expv = exp_q.pop_front();
            if (act !== expv) begin
                n_fail++;
                $display("FAIL outputs at %0t: actual tens=%b ones=%b run=%b lap=%b done=%b, required tens=%b ones=%b run=%b lap=%b done=%b",
                         $time, act[16:10], act[9:3], act[2], act[1], act[0],
                         expv[16:10], expv[9:3], expv[2], expv[1], expv[0]);
            end
        end
    end

    task automatic press_start();
        start_n = 1'b0;
        repeat (3) @(negedge clock);
        start_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    // p_* = 0 disables that stimulus; otherwise about 1 in p_* cycles toggles it
    task automatic run_phase(int cycles, int p_start, int p_lap, int tmode, int p_rst);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            reset = 1'b1;
            if (p_start != 0 && $urandom_range(p_start - 1, 0) == 0) start_n = ~start_n;
            if (p_lap != 0 && $urandom_range(p_lap - 1, 0) == 0) lap_n = ~lap_n;
            if (p_rst != 0 && $urandom_range(p_rst - 1, 0) == 0) reset = 1'b0;
            if ($urandom_range(149, 0) == 0) begin
                if (tmode == 1) begin
                    target_tens = 4'($urandom_range(2, 0));
                    target_ones = 4'($urandom_range(9, 0));
                end else if (tmode == 2) begin
                    target_tens = 4'($urandom_range(15, 0));
                    target_ones = 4'($urandom_range(15, 0));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; start_n = 1'b1; lap_n = 1'b1;
        target_tens = 4'd0; target_ones = 4'd0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        lap_n = 1'b0;
        repeat (4) @(negedge clock);
        lap_n = 1'b1;
        repeat (4) @(negedge clock);
        press_start();
        run_phase(420, 0, 0, 0, 0);
        press_start();
        press_start();
        target_tens = 4'd0; target_ones = 4'd5;
        run_phase(3000, 25, 30, 1, 0);
        run_phase(3000, 25, 30, 2, 700);
        reset = 1'b1;
        start_n = 1'b1;
        lap_n = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (n_wraps == 0 || n_done == 0) begin
            n_fail++;
            $display("FAIL coverage: wraps %0d done_entries %0d, required both nonzero", n_wraps, n_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
